// File: rtl/bcd_display_pkg.sv
// Shared constants, FSM state type and seven-segment glyph table for the
// binary-to-decimal display stage.
package display_pkg;

  localparam int          BIN_W   = 27;
  localparam int          DIGITS  = 8;
  localparam logic [31:0] MAX_DEC = 32'd99_999_999;

  typedef enum logic {IDLE, CONV} state_e;

  // Active-low patterns, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/bcd_display_if.sv
// Handshake and result bus between the GPIO_out producer and the display stage.
interface bcd_display_if #(
  parameter int BIN_W  = display_pkg::BIN_W,
  parameter int DIGITS = display_pkg::DIGITS
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic [4*DIGITS-1:0]   bcd;
  logic                  ovf;
  logic [7*DIGITS-1:0]   seg;

  modport master (
    output in_valid, bin_in,
    input  in_ready, out_valid, bcd, ovf, seg
  );

  modport slave (
    input  in_valid, bin_in,
    output in_ready, out_valid, bcd, ovf, seg
  );
endinterface

// File: rtl/bcd_display_seg7_decode.sv
// One-digit BCD to active-low seven-segment decoder; dash overrides blank,
// blank overrides the glyph, and non-decimal nibbles show nothing.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (dash)                seg = SEG_DASH;
    else if (blank)          seg = SEG_OFF;
    else if (nibble <= 4'd9) seg = SEG_DIGIT[nibble];
  end

endmodule

// File: rtl/bcd_display.sv
// Iterative double-dabble converter (one input bit per clk2) feeding eight
// registered active-low seven-segment digits.
module bcd_display #(
  parameter int BIN_W    = display_pkg::BIN_W,
  parameter int DIGITS   = display_pkg::DIGITS,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic         clk2,
  input  logic         rst,
  bcd_display_if.slave bus
);
  import display_pkg::state_e;
  import display_pkg::IDLE;
  import display_pkg::CONV;
  import display_pkg::MAX_DEC;

  localparam int               ACC_W    = 4 * DIGITS;
  localparam int               SEG_W    = 7 * DIGITS;
  localparam int               CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_next_q, ovf_next_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic               in_ready_q, in_ready_d;

  logic [ACC_W-1:0]   acc_adj, acc_shift;
  logic [DIGITS-1:0]  blank;
  logic [SEG_W-1:0]   seg_dec;

  // One double-dabble step: correct every nibble >= 5, then shift in the next MSB.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    acc_shift = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
  end

  // NOTE: every _d gets a default first so the block never infers a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    ovf_next_d  = ovf_next_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    seg_d       = out_valid_q ? seg_dec : seg_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          bin_d      = bus.bin_in;
          acc_d      = '0;
          cnt_d      = CNT_LOAD;
          ovf_next_d = (32'(bus.bin_in) > MAX_DEC);
          state_d    = CONV;
        end
      end
      CONV: begin
        acc_d = acc_shift;
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          bcd_d       = ovf_next_q ? '0 : acc_shift;
          ovf_d       = ovf_next_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // NOTE: reset is synchronous; rst is only sampled at posedge clk2.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk2) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      ovf_next_q  <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      seg_q       <= {SEG_W{1'b1}};
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      ovf_next_q  <= ovf_next_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      seg_q       <= seg_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // A digit is blank when it and every higher digit are zero; digit 0 always shows.
  always_comb begin : blank_gen
    logic hi_zero;
    hi_zero = 1'b1;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero  = hi_zero && (bcd_q[4*i +: 4] == 4'd0);
      blank[i] = BLANK_LZ && (i != 0) && hi_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_dec (
      .nibble (bcd_q[4*g +: 4]),
      .blank  (blank[g]),
      .dash   (ovf_q),
      .seg    (seg_dec[7*g +: 7])
    );
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd       = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.seg       = seg_q;

endmodule

// File: doc/bcd_display.md
# bcd_display

Sequential binary-to-decimal display stage between the cpu's GPIO_out register and the board's eight seven-segment digits. It accepts a 27-bit unsigned value over a valid/ready handshake and converts it with iterative double-dabble, one bit per clock. It registers the 8-digit packed-BCD result and drives active-low segment patterns for all eight digits. The stage is clocked on clk2, the vector/check clock, so one conversion finishes well within a clk2 test-vector period.

## Interface
Parameters:
- BIN_W, 27, binary input width; 2^27-1 ≥ 99_999_999.
- DIGITS, 8, decimal digits produced.
- BLANK_LZ, 1, blank leading zero digits when 1; digit 0 is never blanked.

Ports:
- clk2  in  1  clock; all state updates on posedge clk2.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  bin_in holds a value to convert.
- in_ready  out  1  block can accept; high only in IDLE.
- bin_in  in  27  unsigned binary value.
- out_valid  out  1  one-cycle pulse; bcd, ovf and seg are updated for the new result.
- bcd  out  32  packed BCD; digit i occupies bits [4i+3:4i].
- ovf  out  1  last accepted value was > 99_999_999.
- seg  out  56  active-low segments; digit i occupies seg[7i+6:7i], in bit order g,f,e,d,c,b,a.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - CONV: in_ready=0.
- Accept: in IDLE, when in_valid && in_ready at an edge:
  - capture bin_in into the shift register;
  - clear the BCD accumulator;
  - load the iteration counter to 26;
  - latch ovf_next = (bin_in > 99_999_999);
  - go to CONV.
- CONV iteration, once per edge:
  - every accumulator nibble ≥5 gets +3;
  - then shift {acc, bin} left by one bit;
  - decrement the counter.
- When counter==0 at the iteration edge:
  - bcd ← final acc; if ovf_next, bcd ← 0 instead;
  - ovf ← ovf_next;
  - out_valid ← 1 for one cycle;
  - go to IDLE.
- bcd, ovf and seg hold their values until the next completion or reset.
- Segment encoding, per digit:
  - ovf=1: every digit shows dash 7'b0111111.
  - else, if BLANK_LZ and the digit and all higher digits are 0 and i≠0: 7'b1111111 (off).
  - else: the standard decimal glyph, e.g. '0'=7'b1000000, '1'=7'b1111001, '8'=7'b0000000.
- Nibble values A–F cannot occur; the decoder maps them to off.
- in_valid while in CONV is ignored: in_ready is 0 and nothing is captured.
- Back-to-back: the out_valid cycle is in IDLE, so a new accept can happen on the next edge.

## Timing
- Accept at edge E0.
- Iterations occur at E1..E27.
- bcd, ovf and out_valid update at E27.
- seg is registered from the new bcd/ovf and updates at E28.
- Accept-to-out_valid latency: 27 clk2 cycles. Minimum spacing between accepts: 28 cycles.
- Reset (rst=0 at an edge), with priority over all other activity:
  - state=IDLE, in_ready=1 after the edge;
  - out_valid=0, bcd=0, ovf=0;
  - seg=all ones (all digits off);
  - counter=0.
- Reset during CONV aborts the conversion; no out_valid is produced.
- in_ready is a registered output derived from state, with no combinational path from in_valid.

## Structure
- Package display_pkg holds:
  - BIN_W, DIGITS, MAX_DEC = 99_999_999;
  - the state enum {IDLE, CONV};
  - segment constants SEG_OFF, SEG_DASH, and the SEG_DIGIT[0:9] array.
- Sub-module seg7_decode: 4-bit nibble plus blank and dash controls in, 7-bit active-low pattern out. It is combinational and instantiated DIGITS times; the outputs are registered in bcd_display.
- Double-dabble datapath, FSM and counter stay in bcd_display.

## Test plan
- Reset then accept 0 → out_valid 27 cycles after accept, bcd=32'h0, ovf=0; one cycle later seg digit0=7'b1000000 and digits 1–7 =7'b1111111.
- Accept 12_345_678 → bcd=32'h12345678; seg digit7=7'b1111001 ('1'), digit0=7'b0000000 ('8').
- Accept 99_999_999 → bcd=32'h99999999, ovf=0. Then accept 100_000_000 → ovf=1, bcd=0, all eight digits=7'b0111111.
- Hold in_valid high with 5, then 7:
  - in_ready=0 for the 27 CONV cycles and 7 is not captured mid-conversion;
  - in the out_valid cycle bcd=32'h5 and 7 is accepted on that edge;
  - the second out_valid follows 27 cycles later with bcd=32'h7.
- Accept 4096 with BLANK_LZ=0 → digits 7–4 show '0' glyphs and bcd=32'h00004096.
- Accept 12_345_678, drive rst=0 at iteration 10 → no out_valid; after the edge bcd=0, seg all ones, in_ready=1. A following accept of 1 completes normally with bcd=32'h1.
